// File: rtl/line_fetch_pkg.sv
// Shared definitions for the cache line fetch engine.
//   - fetch command encodings carried on fetch_cmd
//   - line_fetch_state_t: 4-bit state encoding of the fetch engine
//   - SRAM read priority codes driven on mem_rpri
//   - cmd_is_wb(): decodes fetch_cmd; unknown encodings fall back to a plain fetch
package line_fetch_pkg;

  localparam logic [1:0] FETCH_LINE    = 2'b01;
  localparam logic [1:0] FETCH_WB_LINE = 2'b10;

  localparam logic [1:0] MEM_RPRI_NONE  = 2'b00;
  localparam logic [1:0] MEM_RPRI_FETCH = 2'b01;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StWbCmd  = 4'd1,
    StWbData = 4'd2,
    StWbResp = 4'd3,
    StRdCmd  = 4'd4,
    StRdData = 4'd5,
    StDone   = 4'd6
  } line_fetch_state_t;

  function automatic logic cmd_is_wb(input logic [1:0] cmd);
    case (cmd)
      FETCH_WB_LINE: return 1'b1;
      FETCH_LINE:    return 1'b0;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Two-entry valid/ready FIFO buffering SRAM read data on its way to the bus
// write channel during victim writeback.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     push side (SRAM read data)
//   in_data               push data
//   out_valid/out_ready   pop side (bus write data)
//   out_data              head entry
//   count                 current occupancy, 0..2
// Push and pop in the same cycle leave the occupancy unchanged.
module wb_skid_buf
  import line_fetch_pkg::*;
#(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic [1:0]            count
);

  logic [data_width-1:0] slot_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  push;
  logic                  pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = slot_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/line_fetch.sv
// Line-fill and victim-writeback engine. Accepts one fetch command per line
// miss, optionally streams the dirty victim line from the cache SRAM to the
// bus, then reads the new line from the bus into the SRAM slot named by tag
// and pulses fetch_done.
// Configuration macro: LINE_FETCH_WRITEBACK_EN enables the writeback path
// (WB states and skid buffer). Without it, every command is a plain fetch and
// the SRAM read / bus write outputs are tied to zero.
// Ports:
//   clk, rst_n                               clock, asynchronous active-low reset
//   fetch_req/fetch_gnt                      command handshake from the controller
//   fetch_cmd, fetch_tag                     command and SRAM line slot
//   fetch_addr, fetch_addr_pre               new line / victim line bus addresses
//   fetch_done                               one-cycle completion pulse
//   mem_raddr/mem_ren/mem_rpri/mem_rready    SRAM read request
//   mem_rdata/mem_rdata_valid                SRAM read data (1 cycle after accept)
//   mem_waddr/mem_wen/mem_wdata/mem_wready   SRAM write request
//   bus_cmd_*                                bus line command
//   bus_w*                                   bus write data channel
//   bus_bvalid                               bus write response
//   bus_r*                                   bus read data channel
module line_fetch
  import line_fetch_pkg::*;
#(
  parameter int unsigned addr_width = 32,
  parameter int unsigned list_depth = 4,
  parameter int unsigned data_width = 32,
  parameter int unsigned list_width = 32
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             fetch_req,
  output logic                                             fetch_gnt,
  input  logic [1:0]                                       fetch_cmd,
  input  logic [$clog2(list_depth)-1:0]                    fetch_tag,
  input  logic [addr_width-1:0]                            fetch_addr,
  input  logic [addr_width-1:0]                            fetch_addr_pre,
  output logic                                             fetch_done,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_raddr,
  output logic                                             mem_ren,
  output logic [1:0]                                       mem_rpri,
  input  logic                                             mem_rready,
  input  logic [data_width-1:0]                            mem_rdata,
  input  logic                                             mem_rdata_valid,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_waddr,
  output logic                                             mem_wen,
  output logic [data_width-1:0]                            mem_wdata,
  input  logic                                             mem_wready,
  output logic                                             bus_cmd_valid,
  input  logic                                             bus_cmd_ready,
  output logic                                             bus_cmd_we,
  output logic [addr_width-1:0]                            bus_cmd_addr,
  output logic                                             bus_wvalid,
  input  logic                                             bus_wready,
  output logic [data_width-1:0]                            bus_wdata,
  output logic                                             bus_wlast,
  input  logic                                             bus_bvalid,
  input  logic                                             bus_rvalid,
  output logic                                             bus_rready,
  input  logic [data_width-1:0]                            bus_rdata
);

  localparam int unsigned tag_w = $clog2(list_depth);
  localparam int unsigned off_w = $clog2(list_width);
  localparam logic [off_w-1:0] last_off = off_w'(list_width - 1);
  localparam logic [off_w-1:0] one_off  = off_w'(1);

  line_fetch_state_t  state_q;
  logic [tag_w-1:0]   tag_q;
  logic [off_w-1:0]   wr_cnt_q;
  logic               wr_beat;

  assign fetch_gnt = fetch_req && (state_q == StIdle);

  // Fill path: the bus read channel is throttled directly by SRAM write ready.
  assign bus_rready = (state_q == StRdData) && mem_wready;
  assign mem_wen    = (state_q == StRdData) && bus_rvalid;
  assign mem_waddr  = mem_wen ? {tag_q, wr_cnt_q} : '0;
  assign mem_wdata  = mem_wen ? bus_rdata : '0;
  assign wr_beat    = mem_wen && mem_wready;

`ifdef LINE_FETCH_WRITEBACK_EN
  logic [addr_width-1:0] addr_q;
  logic [off_w-1:0]      rd_cnt_q;
  logic [off_w-1:0]      beat_cnt_q;
  logic                  rd_all_q;
  logic                  inflight_q;
  logic [1:0]            skid_count;
  logic                  skid_out_valid;
  logic                  skid_out_ready;
  logic                  skid_in_ready_unused;
  logic [data_width-1:0] skid_out_data;
  logic                  skid_push;
  logic                  skid_pop;
  logic                  rd_accept;
  logic [2:0]            occ_after;

  assign skid_push      = (state_q == StWbData) && mem_rdata_valid;
  assign skid_out_ready = (state_q == StWbData) && bus_wready;
  assign bus_wvalid     = (state_q == StWbData) && skid_out_valid;
  assign skid_pop       = bus_wvalid && bus_wready;
  assign bus_wdata      = bus_wvalid ? skid_out_data : '0;
  assign bus_wlast      = bus_wvalid && (beat_cnt_q == last_off);

  // Buffered plus in-flight words, crediting a pop happening this cycle so
  // that a full-rate stream keeps one read issued per cycle without ever
  // holding more than two words.
  assign occ_after = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, skid_pop};
  assign mem_ren   = (state_q == StWbData) && !rd_all_q && (occ_after < 3'd2);
  assign mem_raddr = mem_ren ? {tag_q, rd_cnt_q} : '0;
  assign mem_rpri  = mem_ren ? MEM_RPRI_FETCH : MEM_RPRI_NONE;
  assign rd_accept = mem_ren && mem_rready;

  wb_skid_buf #(
    .data_width(data_width)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (skid_push),
    .in_ready (skid_in_ready_unused),
    .in_data  (mem_rdata),
    .out_valid(skid_out_valid),
    .out_ready(skid_out_ready),
    .out_data (skid_out_data),
    .count    (skid_count)
  );
`else
  logic unused_inputs;
  assign unused_inputs = ^{fetch_cmd, fetch_addr_pre, mem_rready, mem_rdata, mem_rdata_valid,
                           bus_wready, bus_bvalid};

  assign mem_ren    = 1'b0;
  assign mem_raddr  = '0;
  assign mem_rpri   = MEM_RPRI_NONE;
  assign bus_wvalid = 1'b0;
  assign bus_wdata  = '0;
  assign bus_wlast  = 1'b0;
  assign bus_cmd_we = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      tag_q         <= '0;
      wr_cnt_q      <= '0;
      fetch_done    <= 1'b0;
      bus_cmd_valid <= 1'b0;
      bus_cmd_addr  <= '0;
`ifdef LINE_FETCH_WRITEBACK_EN
      bus_cmd_we    <= 1'b0;
      addr_q        <= '0;
      rd_cnt_q      <= '0;
      beat_cnt_q    <= '0;
      rd_all_q      <= 1'b0;
      inflight_q    <= 1'b0;
`endif
    end else begin
      fetch_done <= 1'b0;
`ifdef LINE_FETCH_WRITEBACK_EN
      // SRAM returns data exactly one cycle after an accepted read.
      inflight_q <= rd_accept;
`endif
      unique case (state_q)
        StIdle: begin
          wr_cnt_q <= '0;
`ifdef LINE_FETCH_WRITEBACK_EN
          rd_cnt_q   <= '0;
          beat_cnt_q <= '0;
          rd_all_q   <= 1'b0;
`endif
          if (fetch_gnt) begin
            tag_q         <= fetch_tag;
            bus_cmd_valid <= 1'b1;
`ifdef LINE_FETCH_WRITEBACK_EN
            addr_q <= fetch_addr;
            if (cmd_is_wb(fetch_cmd)) begin
              state_q      <= StWbCmd;
              bus_cmd_we   <= 1'b1;
              bus_cmd_addr <= fetch_addr_pre;
            end else begin
              state_q      <= StRdCmd;
              bus_cmd_we   <= 1'b0;
              bus_cmd_addr <= fetch_addr;
            end
`else
            state_q      <= StRdCmd;
            bus_cmd_addr <= fetch_addr;
`endif
          end
        end
`ifdef LINE_FETCH_WRITEBACK_EN
        StWbCmd: begin
          if (bus_cmd_ready) begin
            bus_cmd_valid <= 1'b0;
            bus_cmd_we    <= 1'b0;
            bus_cmd_addr  <= '0;
            state_q       <= StWbData;
          end
        end
        StWbData: begin
          if (rd_accept) begin
            rd_cnt_q <= rd_cnt_q + one_off;
            if (rd_cnt_q == last_off) begin
              rd_all_q <= 1'b1;
            end
          end
          if (skid_pop) begin
            beat_cnt_q <= beat_cnt_q + one_off;
            if (beat_cnt_q == last_off) begin
              state_q <= StWbResp;
            end
          end
        end
        StWbResp: begin
          if (bus_bvalid) begin
            bus_cmd_valid <= 1'b1;
            bus_cmd_we    <= 1'b0;
            bus_cmd_addr  <= addr_q;
            state_q       <= StRdCmd;
          end
        end
`endif
        StRdCmd: begin
          if (bus_cmd_ready) begin
            bus_cmd_valid <= 1'b0;
            bus_cmd_addr  <= '0;
            state_q       <= StRdData;
          end
        end
        StRdData: begin
          if (wr_beat) begin
            wr_cnt_q <= wr_cnt_q + one_off;
            if (wr_cnt_q == last_off) begin
              fetch_done <= 1'b1;
              state_q    <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch with list_width=4, list_depth=4.
// Responds as SRAM and bus, logs every handshake, and compares the logs with
// hand-computed expectations. Writeback scenarios are selected by
// LINE_FETCH_WRITEBACK_EN to match the build of the design.
module tb_line_fetch;
  import line_fetch_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned LD  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 4;
  localparam int unsigned TW  = $clog2(LD);
  localparam int unsigned MAW = $clog2(LD) + $clog2(LW);

  logic           clk;
  logic           rst_n;
  logic           fetch_req;
  logic           fetch_gnt;
  logic [1:0]     fetch_cmd;
  logic [TW-1:0]  fetch_tag;
  logic [AW-1:0]  fetch_addr;
  logic [AW-1:0]  fetch_addr_pre;
  logic           fetch_done;
  logic [MAW-1:0] mem_raddr;
  logic           mem_ren;
  logic [1:0]     mem_rpri;
  logic           mem_rready;
  logic [DW-1:0]  mem_rdata;
  logic           mem_rdata_valid;
  logic [MAW-1:0] mem_waddr;
  logic           mem_wen;
  logic [DW-1:0]  mem_wdata;
  logic           mem_wready;
  logic           bus_cmd_valid;
  logic           bus_cmd_ready;
  logic           bus_cmd_we;
  logic [AW-1:0]  bus_cmd_addr;
  logic           bus_wvalid;
  logic           bus_wready;
  logic [DW-1:0]  bus_wdata;
  logic           bus_wlast;
  logic           bus_bvalid;
  logic           bus_rvalid;
  logic           bus_rready;
  logic [DW-1:0]  bus_rdata;

  line_fetch #(
    .addr_width(AW),
    .list_depth(LD),
    .data_width(DW),
    .list_width(LW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_req      (fetch_req),
    .fetch_gnt      (fetch_gnt),
    .fetch_cmd      (fetch_cmd),
    .fetch_tag      (fetch_tag),
    .fetch_addr     (fetch_addr),
    .fetch_addr_pre (fetch_addr_pre),
    .fetch_done     (fetch_done),
    .mem_raddr      (mem_raddr),
    .mem_ren        (mem_ren),
    .mem_rpri       (mem_rpri),
    .mem_rready     (mem_rready),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_waddr      (mem_waddr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wready     (mem_wready),
    .bus_cmd_valid  (bus_cmd_valid),
    .bus_cmd_ready  (bus_cmd_ready),
    .bus_cmd_we     (bus_cmd_we),
    .bus_cmd_addr   (bus_cmd_addr),
    .bus_wvalid     (bus_wvalid),
    .bus_wready     (bus_wready),
    .bus_wdata      (bus_wdata),
    .bus_wlast      (bus_wlast),
    .bus_bvalid     (bus_bvalid),
    .bus_rvalid     (bus_rvalid),
    .bus_rready     (bus_rready),
    .bus_rdata      (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  logic [DW-1:0]  sram [16];
  logic [DW-1:0]  bw_data_q [$];
  logic           bw_last_q [$];
  logic [MAW-1:0] sw_addr_q [$];
  logic [DW-1:0]  sw_data_q [$];
  logic           cmd_we_q [$];
  logic [AW-1:0]  cmd_addr_q [$];
  int gnt_cnt, gnt_cyc, done_cnt, done_cyc, n_reads, max_out;
  int stall_bad, stall_seen, first_beat_cyc, last_beat_cyc;
  bit finished;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{fetch_gnt, fetch_done, mem_raddr, mem_ren, mem_rpri, mem_waddr, mem_wen, mem_wdata,
             bus_cmd_valid, bus_cmd_we, bus_cmd_addr, bus_wvalid, bus_wdata, bus_wlast,
             bus_rready};
  endfunction

  task automatic idle_inputs();
    fetch_req       = 1'b0;
    fetch_cmd       = 2'b00;
    fetch_tag       = '0;
    fetch_addr      = '0;
    fetch_addr_pre  = '0;
    mem_rready      = 1'b0;
    mem_rdata       = '0;
    mem_rdata_valid = 1'b0;
    mem_wready      = 1'b0;
    bus_cmd_ready   = 1'b0;
    bus_wready      = 1'b0;
    bus_bvalid      = 1'b0;
    bus_rvalid      = 1'b0;
    bus_rdata       = '0;
  endtask

  // One fetch command, driven and observed cycle by cycle. bp_mode 1 drives
  // bus_wready as 1,0,0 repeating; stall holds mem_wready low for 3 cycles at
  // fill beat 2; rst_mid pulses reset at fill beat 2.
  task automatic run_op(input logic [1:0] cmd, input logic [TW-1:0] tag,
                        input logic [AW-1:0] addr, input logic [AW-1:0] addr_pre,
                        input int bp_mode, input bit stall, input bit rst_mid,
                        input logic [DW-1:0] base);
    bit rd_active, rd_pend, bv_next, stall_done;
    int rbeat, stall_left, out_cnt;
    logic [MAW-1:0] rd_addr_saved;
    bw_data_q.delete(); bw_last_q.delete(); sw_addr_q.delete(); sw_data_q.delete();
    cmd_we_q.delete(); cmd_addr_q.delete();
    gnt_cnt = 0; gnt_cyc = -1; done_cnt = 0; done_cyc = -1; n_reads = 0; max_out = 0;
    stall_bad = 0; stall_seen = 0; first_beat_cyc = -1; last_beat_cyc = -1;
    finished = 0; rd_active = 0; rd_pend = 0; bv_next = 0; stall_done = 0;
    rbeat = 0; stall_left = 0; out_cnt = 0; rd_addr_saved = '0;
    for (int k = 0; k < 300 && !finished; k++) begin
      @(negedge clk);
      fetch_req       = 1'b1;
      fetch_cmd       = cmd;
      fetch_tag       = tag;
      fetch_addr      = addr;
      fetch_addr_pre  = addr_pre;
      bus_cmd_ready   = 1'b1;
      mem_rready      = 1'b1;
      mem_rdata_valid = rd_pend;
      mem_rdata       = rd_pend ? sram[rd_addr_saved] : '0;
      bus_bvalid      = bv_next;
      bv_next         = 0;
      bus_wready      = (bp_mode == 0) ? 1'b1 : (k % 3 == 0);
      bus_rvalid      = rd_active && (rbeat < LW);
      bus_rdata       = base + DW'(rbeat);
      if (stall && rd_active && rbeat == 2 && !stall_done) begin
        stall_left = 3;
        stall_done = 1;
      end
      mem_wready = (stall_left == 0);
      if (rst_mid && rd_active && rbeat == 2) begin
        fetch_req = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("rst_mid_outputs_zero", any_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) begin
          @(negedge clk);
          #1;
          if (fetch_done) done_cnt++;
        end
        break;
      end
      #1;
      if (fetch_gnt) begin
        gnt_cnt++;
        if (gnt_cyc < 0) gnt_cyc = k;
      end
      if (bus_cmd_valid && bus_cmd_ready) begin
        cmd_we_q.push_back(bus_cmd_we);
        cmd_addr_q.push_back(bus_cmd_addr);
        if (!bus_cmd_we) rd_active = 1;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      rd_pend = mem_ren && mem_rready;
      rd_addr_saved = mem_raddr;
      if (rd_pend) begin
        n_reads++;
        out_cnt++;
      end
      if (bus_wvalid && bus_wready) begin
        bw_data_q.push_back(bus_wdata);
        bw_last_q.push_back(bus_wlast);
        if (first_beat_cyc < 0) first_beat_cyc = k;
        last_beat_cyc = k;
        out_cnt--;
        if (bus_wlast) bv_next = 1;
      end
      if (mem_wen && mem_wready) begin
        sw_addr_q.push_back(mem_waddr);
        sw_data_q.push_back(mem_wdata);
      end
      if (bus_rvalid && bus_rready) rbeat++;
      if (stall_left > 0) begin
        stall_seen++;
        if (bus_rready) stall_bad++;
        stall_left--;
      end
      if (fetch_done) begin
        done_cnt++;
        done_cyc = k;
        finished = 1;
      end
    end
    idle_inputs();
  endtask

  task automatic check_fill(input string tag, input int slot, input logic [DW-1:0] base);
    check_eq({tag, "_sram_wr_count"}, sw_addr_q.size(), LW);
    for (int i = 0; i < sw_addr_q.size() && i < LW; i++) begin
      check_eq({tag, "_sram_waddr"}, sw_addr_q[i], slot * LW + i);
      check_eq({tag, "_sram_wdata"}, sw_data_q[i], base + DW'(i));
    end
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) sram[i] = 32'hDEAD_0000 + i;
    for (int i = 0; i < 4; i++) sram[4 + i] = 32'h5700_0000 + i;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs_zero", any_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch only: tag 2, line 0x100, beats A0..A3.
    run_op(2'b01, 2'd2, 32'h100, 32'h0, 0, 1'b0, 1'b0, 32'hA0);
    check_eq("fo_cmd_count", cmd_we_q.size(), 1);
    if (cmd_we_q.size() > 0) begin
      check_eq("fo_cmd_we", cmd_we_q[0], 0);
      check_eq("fo_cmd_addr", cmd_addr_q[0], 32'h100);
    end
    check_fill("fo", 2, 32'hA0);
    check_eq("fo_latency", done_cyc - gnt_cyc, 6);
    check_eq("fo_single_grant", gnt_cnt, 1);
    check_eq("fo_no_bus_write", bw_data_q.size(), 0);

`ifdef LINE_FETCH_WRITEBACK_EN
    // Writeback of tag 1 to 0x80, then fetch 0x200.
    run_op(2'b10, 2'd1, 32'h200, 32'h80, 0, 1'b0, 1'b0, 32'hB0);
    check_eq("wb_cmd_count", cmd_we_q.size(), 2);
    if (cmd_we_q.size() > 1) begin
      check_eq("wb_cmd0_we", cmd_we_q[0], 1);
      check_eq("wb_cmd0_addr", cmd_addr_q[0], 32'h80);
      check_eq("wb_cmd1_we", cmd_we_q[1], 0);
      check_eq("wb_cmd1_addr", cmd_addr_q[1], 32'h200);
    end
    check_eq("wb_beat_count", bw_data_q.size(), LW);
    for (int i = 0; i < bw_data_q.size() && i < LW; i++) begin
      check_eq("wb_wdata", bw_data_q[i], 32'h5700_0000 + i);
      check_eq("wb_wlast", bw_last_q[i], (i == LW - 1));
    end
    check_eq("wb_full_rate", last_beat_cyc - first_beat_cyc, LW - 1);
    check_eq("wb_outstanding_le2", (max_out <= 2), 1);
    check_eq("wb_single_grant", gnt_cnt, 1);
    check_fill("wb", 1, 32'hB0);

    // Writeback under bus_wready backpressure.
    run_op(2'b10, 2'd1, 32'h300, 32'h40, 1, 1'b0, 1'b0, 32'hC0);
    check_eq("bp_beat_count", bw_data_q.size(), LW);
    for (int i = 0; i < bw_data_q.size() && i < LW; i++) begin
      check_eq("bp_wdata", bw_data_q[i], 32'h5700_0000 + i);
    end
    check_eq("bp_reads", n_reads, LW);
    check_eq("bp_outstanding_le2", (max_out <= 2), 1);
    check_fill("bp", 1, 32'hC0);
`else
    // Writeback command without the writeback path: plain fill only.
    run_op(2'b10, 2'd1, 32'h200, 32'h80, 0, 1'b0, 1'b0, 32'hB0);
    check_eq("nowb_cmd_count", cmd_we_q.size(), 1);
    if (cmd_we_q.size() > 0) begin
      check_eq("nowb_cmd_we", cmd_we_q[0], 0);
      check_eq("nowb_cmd_addr", cmd_addr_q[0], 32'h200);
    end
    check_eq("nowb_no_bus_write", bw_data_q.size(), 0);
    check_eq("nowb_no_sram_read", n_reads, 0);
    check_fill("nowb", 1, 32'hB0);
`endif

    // SRAM write stall for 3 cycles at beat 2.
    run_op(2'b01, 2'd3, 32'h400, 32'h0, 0, 1'b1, 1'b0, 32'hD0);
    check_eq("stall_cycles", stall_seen, 3);
    check_eq("stall_rready_low", stall_bad, 0);
    check_fill("stall", 3, 32'hD0);

    // Reset during fill beat 2, then a fresh request.
    run_op(2'b01, 2'd0, 32'h500, 32'h0, 0, 1'b0, 1'b1, 32'hE0);
    check_eq("rst_mid_no_done", done_cnt, 0);
    check_eq("rst_mid_partial_writes", sw_addr_q.size(), 2);
    run_op(2'b01, 2'd0, 32'h600, 32'h0, 0, 1'b0, 1'b0, 32'hF0);
    check_eq("regrant_first_cycle", gnt_cyc, 0);
    check_fill("regrant", 0, 32'hF0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
